// File: rtl/pmt_pulse_conditioner_if.sv
// PMT conditioner bus: discriminator/reference inputs, event stamp and statistics outputs.
interface pmt_pulse_conditioner_if #(
  parameter int TS_WIDTH = 32
);
  logic                PMT_in;
  logic [TS_WIDTH-1:0] light_timer;
  logic                in_phase;
  logic                quadrature;
  logic                clear_counts;
  logic                pulse_event;
  logic [TS_WIDTH-1:0] event_light_timer;
  logic                event_in_phase;
  logic                event_quadrature;
  logic [31:0]         accepted_count;
  logic [31:0]         glitch_count;
  logic [31:0]         deadtime_count;

  modport master (
    output PMT_in, light_timer, in_phase, quadrature, clear_counts,
    input  pulse_event, event_light_timer, event_in_phase, event_quadrature,
           accepted_count, glitch_count, deadtime_count
  );

  modport slave (
    input  PMT_in, light_timer, in_phase, quadrature, clear_counts,
    output pulse_event, event_light_timer, event_in_phase, event_quadrature,
           accepted_count, glitch_count, deadtime_count
  );
endinterface

// File: rtl/pmt_pulse_conditioner.sv
// PMT pulse conditioner: synchronize, width-qualify, non-paralyzable dead time,
// I/Q phase stamping and saturating statistics.
module pmt_pulse_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_WIDTH   = 2,
  parameter int DEAD_TIME   = 10,
  parameter int TS_WIDTH    = 32
) (
  input  logic                   main_clock,
  input  logic                   reset,
  pmt_pulse_conditioner_if.slave bus
);
  localparam int WW = $clog2(MIN_WIDTH + 1);
  localparam int DW = $clog2(DEAD_TIME + 2);
  localparam logic [WW-1:0] W_LAST = WW'(MIN_WIDTH - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEAD_TIME);

  typedef enum logic [1:0] {IDLE = 2'd0, QUALIFY = 2'd1, DEAD = 2'd2} state_t;

  state_t               state, nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                 s, s_prev, rise;
  logic [WW-1:0]        wcnt;
  logic [DW-1:0]        dcnt;
  logic                 latch_en, accept, glitch, dead_hit;
  logic                 pulse_q;
  logic [TS_WIDTH-1:0]  stamp_lt;
  logic                 stamp_i, stamp_q;
  logic [31:0]          acc_cnt, glt_cnt, dt_cnt;

  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~s_prev;

  // Flops preset high so a level already high at reset release is not an edge.
  always_ff @(posedge main_clock) begin
    if (reset) begin
      sync   <= '1;
      s_prev <= 1'b1;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], bus.PMT_in};
      s_prev <= s;
    end
  end

  always_ff @(posedge main_clock) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (rise) nxt = (MIN_WIDTH == 1) ? DEAD : QUALIFY;
      QUALIFY: if (!s) nxt = IDLE;
               else if (wcnt == W_LAST) nxt = DEAD;
      DEAD:    if (dcnt == D_LAST) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    latch_en = 1'b0;
    accept   = 1'b0;
    glitch   = 1'b0;
    dead_hit = 1'b0;
    case (state)
      IDLE: begin
        latch_en = rise;
        accept   = rise && (MIN_WIDTH == 1);
      end
      QUALIFY: begin
        glitch = !s;
        accept = s && (wcnt == W_LAST);
      end
      DEAD:    dead_hit = rise;
      default: ;
    endcase
  end

  // dcnt is 1 in the pulse_event cycle, so DEAD spans exactly DEAD_TIME cycles.
  always_ff @(posedge main_clock) begin
    if (reset) begin
      wcnt     <= '0;
      dcnt     <= '0;
      pulse_q  <= 1'b0;
      stamp_lt <= '0;
      stamp_i  <= 1'b0;
      stamp_q  <= 1'b0;
    end else begin
      pulse_q <= accept;
      if (latch_en) begin
        stamp_lt <= bus.light_timer;
        stamp_i  <= bus.in_phase;
        stamp_q  <= bus.quadrature;
        wcnt     <= WW'(1);
      end else if (state == QUALIFY) begin
        wcnt <= wcnt + 1'b1;
      end
      if (accept)             dcnt <= DW'(1);
      else if (state == DEAD) dcnt <= dcnt + 1'b1;
    end
  end

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge main_clock) begin
    if (reset || bus.clear_counts) begin
      acc_cnt <= '0;
      glt_cnt <= '0;
      dt_cnt  <= '0;
    end else begin
      if (accept)   acc_cnt <= sat_inc(acc_cnt);
      if (glitch)   glt_cnt <= sat_inc(glt_cnt);
      if (dead_hit) dt_cnt  <= sat_inc(dt_cnt);
    end
  end

  assign bus.pulse_event       = pulse_q;
  assign bus.event_light_timer = stamp_lt;
  assign bus.event_in_phase    = stamp_i;
  assign bus.event_quadrature  = stamp_q;
  assign bus.accepted_count    = acc_cnt;
  assign bus.glitch_count      = glt_cnt;
  assign bus.deadtime_count    = dt_cnt;
endmodule

// File: tb/tb_pmt_pulse_conditioner.sv
// Directed bench for pmt_pulse_conditioner: default instance plus a MIN_WIDTH=1 instance.
module tb_pmt_pulse_conditioner;
  logic main_clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  pmt_pulse_conditioner_if #(.TS_WIDTH(32)) bus0 ();
  pmt_pulse_conditioner_if #(.TS_WIDTH(32)) bus1 ();

  pmt_pulse_conditioner dut (
    .main_clock(main_clock), .reset(reset), .bus(bus0.slave)
  );
  pmt_pulse_conditioner #(.MIN_WIDTH(1), .DEAD_TIME(3)) dut1 (
    .main_clock(main_clock), .reset(reset), .bus(bus1.slave)
  );

  always #5 main_clock = ~main_clock;

  // Drive one cycle of inputs (both instances), then land 1 time unit after the next edge.
  task automatic cyc(input logic p, input logic [31:0] lt, input logic i, input logic q,
                     input logic clr);
    bus0.PMT_in = p; bus0.light_timer = lt; bus0.in_phase = i; bus0.quadrature = q;
    bus0.clear_counts = clr;
    bus1.PMT_in = p; bus1.light_timer = lt; bus1.in_phase = i; bus1.quadrature = q;
    bus1.clear_counts = clr;
    @(posedge main_clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(1, 32'h55, 1, 1, 0);
    cyc(1, 32'h55, 1, 1, 0);
    n_cmp++; if (bus0.pulse_event !== 1'b0) begin n_bad++; $display("FAIL rst_pulse: got %b want 0", bus0.pulse_event); end
    n_cmp++; if (bus0.event_light_timer !== 32'd0) begin n_bad++; $display("FAIL rst_stamp: got %0h want 0", bus0.event_light_timer); end
    n_cmp++; if ({bus0.event_in_phase, bus0.event_quadrature} !== 2'b00) begin n_bad++; $display("FAIL rst_iq: got %b%b want 00", bus0.event_in_phase, bus0.event_quadrature); end
    n_cmp++; if (bus0.accepted_count !== 32'd0 || bus0.glitch_count !== 32'd0 || bus0.deadtime_count !== 32'd0) begin
      n_bad++; $display("FAIL rst_counts: got %0h/%0h/%0h want 0/0/0", bus0.accepted_count, bus0.glitch_count, bus0.deadtime_count); end
    n_cmp++; if (dut.state !== 2'd0) begin n_bad++; $display("FAIL rst_state: got %0d want 0", dut.state); end
    n_cmp++; if (dut.s_prev !== 1'b1 || dut.sync !== 2'b11) begin n_bad++; $display("FAIL rst_sync: got %b/%b want 1/11", dut.s_prev, dut.sync); end
  endtask

  // PMT high C0..C4 -> edge E=C2, event at C4 stamped with cycle-2 inputs.
  task automatic test_single_pulse();
    logic [31:0] pat = 32'h0000_001F;
    do_reset();
    for (int n = 0; n < 12; n++) begin
      cyc(pat[n], (n == 2) ? 32'd123 : 32'd1000 + n, n == 2, n != 2, 0);
      n_cmp++; if (bus0.pulse_event !== (n + 1 == 4)) begin n_bad++; $display("FAIL single_pulse c%0d: got %b want %b", n + 1, bus0.pulse_event, n + 1 == 4); end
      if (n + 1 == 4) begin
        n_cmp++; if (bus0.event_light_timer !== 32'd123) begin n_bad++; $display("FAIL single_stamp: got %0d want 123", bus0.event_light_timer); end
        n_cmp++; if ({bus0.event_in_phase, bus0.event_quadrature} !== 2'b10) begin n_bad++; $display("FAIL single_iq: got %b%b want 10", bus0.event_in_phase, bus0.event_quadrature); end
        n_cmp++; if (bus0.accepted_count !== 32'd1) begin n_bad++; $display("FAIL single_acc: got %0d want 1", bus0.accepted_count); end
      end
    end
    n_cmp++; if (bus0.event_light_timer !== 32'd123) begin n_bad++; $display("FAIL single_hold: got %0d want 123", bus0.event_light_timer); end
  endtask

  task automatic test_glitch();
    logic [31:0] pat = 32'h0000_0001;
    do_reset();
    for (int n = 0; n < 8; n++) begin
      cyc(pat[n], 32'd1000 + n, 0, 0, 0);
      n_cmp++; if (bus0.pulse_event !== 1'b0) begin n_bad++; $display("FAIL glitch_pulse c%0d: got %b want 0", n + 1, bus0.pulse_event); end
    end
    n_cmp++; if (bus0.glitch_count !== 32'd1) begin n_bad++; $display("FAIL glitch_cnt: got %0d want 1", bus0.glitch_count); end
    n_cmp++; if (bus0.accepted_count !== 32'd0) begin n_bad++; $display("FAIL glitch_acc: got %0d want 0", bus0.accepted_count); end
    n_cmp++; if (dut.state !== 2'd0) begin n_bad++; $display("FAIL glitch_state: got %0d want 0", dut.state); end
  endtask

  // Event at C4; edge at C8 (event+4) hits dead time; edge at C16 (event+12) accepted at C18.
  task automatic test_back_to_back();
    logic [31:0] pat = 32'h0000_C0C3;
    logic [31:0] exp = 32'h0004_0010;
    do_reset();
    for (int n = 0; n < 22; n++) begin
      cyc(pat[n], 32'd1000 + n, 0, 0, 0);
      n_cmp++; if (bus0.pulse_event !== exp[n+1]) begin n_bad++; $display("FAIL b2b_pulse c%0d: got %b want %b", n + 1, bus0.pulse_event, exp[n+1]); end
      if (n + 1 == 9) begin
        n_cmp++; if (bus0.deadtime_count !== 32'd1) begin n_bad++; $display("FAIL b2b_dead_c9: got %0d want 1", bus0.deadtime_count); end
      end
    end
    n_cmp++; if (bus0.event_light_timer !== 32'd1016) begin n_bad++; $display("FAIL b2b_stamp: got %0d want 1016", bus0.event_light_timer); end
    n_cmp++; if (bus0.accepted_count !== 32'd2 || bus0.deadtime_count !== 32'd1 || bus0.glitch_count !== 32'd0) begin
      n_bad++; $display("FAIL b2b_counts: got %0d/%0d/%0d want 2/0/1", bus0.accepted_count, bus0.glitch_count, bus0.deadtime_count); end
  endtask

  // PMT high through reset release, low C4..C6, high from C7 -> single event at C11.
  task automatic test_reset_high();
    reset = 1'b1;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    reset = 1'b0;
    for (int n = 0; n < 20; n++) begin
      cyc((n <= 3) || (n >= 7), 32'd1000 + n, 0, 0, 0);
      n_cmp++; if (bus0.pulse_event !== (n + 1 == 11)) begin n_bad++; $display("FAIL rsthigh_pulse c%0d: got %b want %b", n + 1, bus0.pulse_event, n + 1 == 11); end
    end
    n_cmp++; if (bus0.accepted_count !== 32'd1) begin n_bad++; $display("FAIL rsthigh_acc: got %0d want 1", bus0.accepted_count); end
  endtask

  task automatic test_saturation();
    logic [31:0] pat = 32'h0030_0003;
    do_reset();
    force dut.acc_cnt = 32'hFFFF_FFFF;
    cyc(0, 0, 0, 0, 0);
    release dut.acc_cnt;
    cyc(0, 0, 0, 0, 0);
    n_cmp++; if (bus0.accepted_count !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sat_preload: got %0h want ffffffff", bus0.accepted_count); end
    for (int n = 0; n < 26; n++) begin
      cyc(pat[n], 32'd2000 + n, 0, 0, n == 23);
      if (n + 1 == 4 || n + 1 == 24) begin
        n_cmp++; if (bus0.pulse_event !== 1'b1) begin n_bad++; $display("FAIL sat_pulse c%0d: got %b want 1", n + 1, bus0.pulse_event); end
      end
      if (n + 1 == 5) begin
        n_cmp++; if (bus0.accepted_count !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sat_hold: got %0h want ffffffff", bus0.accepted_count); end
      end
      if (n + 1 == 24) begin
        n_cmp++; if (bus0.accepted_count !== 32'd0) begin n_bad++; $display("FAIL sat_clear_wins: got %0h want 0", bus0.accepted_count); end
        n_cmp++; if (bus0.event_light_timer !== 32'd2022) begin n_bad++; $display("FAIL sat_stamp: got %0d want 2022", bus0.event_light_timer); end
      end
    end
  endtask

  // Glitch first (counter 1), then reset in C11 aborts the pulse whose edge is C10.
  task automatic test_reset_abort();
    logic [31:0] pat = 32'h0000_1F01;
    do_reset();
    for (int n = 0; n < 20; n++) begin
      reset = (n == 11);
      cyc(pat[n], 32'd1000 + n, 1, 1, 0);
      n_cmp++; if (bus0.pulse_event !== 1'b0) begin n_bad++; $display("FAIL abort_pulse c%0d: got %b want 0", n + 1, bus0.pulse_event); end
      if (n + 1 == 6) begin
        n_cmp++; if (bus0.glitch_count !== 32'd1) begin n_bad++; $display("FAIL abort_pre_glitch: got %0d want 1", bus0.glitch_count); end
      end
      if (n + 1 == 12) begin
        n_cmp++; if (bus0.accepted_count !== 32'd0 || bus0.glitch_count !== 32'd0 || bus0.deadtime_count !== 32'd0) begin
          n_bad++; $display("FAIL abort_counts: got %0d/%0d/%0d want 0/0/0", bus0.accepted_count, bus0.glitch_count, bus0.deadtime_count); end
        n_cmp++; if (dut.state !== 2'd0) begin n_bad++; $display("FAIL abort_state: got %0d want 0", dut.state); end
        n_cmp++; if (bus0.event_light_timer !== 32'd0) begin n_bad++; $display("FAIL abort_stamp: got %0d want 0", bus0.event_light_timer); end
      end
    end
    reset = 1'b0;
  endtask

  // One-cycle pulses: MIN_WIDTH=1 instance accepts at E+1, default instance counts glitches.
  task automatic test_min_width_one();
    logic [31:0] pat = 32'h0000_0101;
    logic [31:0] exp = 32'h0000_0808;
    do_reset();
    for (int n = 0; n < 14; n++) begin
      cyc(pat[n], 32'd1000 + n, n == 2, 0, 0);
      n_cmp++; if (bus1.pulse_event !== exp[n+1]) begin n_bad++; $display("FAIL mw1_pulse c%0d: got %b want %b", n + 1, bus1.pulse_event, exp[n+1]); end
      if (n + 1 == 3) begin
        n_cmp++; if (bus1.event_light_timer !== 32'd1002 || bus1.event_in_phase !== 1'b1) begin
          n_bad++; $display("FAIL mw1_stamp: got %0d/%b want 1002/1", bus1.event_light_timer, bus1.event_in_phase); end
      end
    end
    n_cmp++; if (bus1.accepted_count !== 32'd2) begin n_bad++; $display("FAIL mw1_acc: got %0d want 2", bus1.accepted_count); end
    n_cmp++; if (bus0.glitch_count !== 32'd2 || bus0.accepted_count !== 32'd0) begin
      n_bad++; $display("FAIL mw2_glitch: got %0d/%0d want 2/0", bus0.glitch_count, bus0.accepted_count); end
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_glitch();
    test_back_to_back();
    test_reset_high();
    test_saturation();
    test_reset_abort();
    test_min_width_one();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pmt_pulse_conditioner.md
PMT_PULSE_CONDITIONER -- requirements
Module: pmt_pulse_conditioner

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer flop count on PMT_in; legal values 2..4.
REQ-002 SHALL have parameter MIN_WIDTH, default 2: minimum high time in main_clock cycles for a pulse to qualify; legal values >= 1.
REQ-003 SHALL have parameter DEAD_TIME, default 10: non-paralyzable dead time in cycles after an accepted event; legal values >= 1.
REQ-004 SHALL have parameter TS_WIDTH, default 32: width of the light_timer phase stamp.
REQ-005 main_clock  in  1  sole clock; all logic is on the rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 PMT_in  in  1  asynchronous PMT discriminator output.
REQ-008 light_timer  in  TS_WIDTH  modulation-period phase counter, synchronous to main_clock.
REQ-009 in_phase  in  1  I reference level, synchronous.
REQ-010 quadrature  in  1  Q reference level, synchronous.
REQ-011 clear_counts  in  1  single-cycle request to zero the statistics counters.
REQ-012 pulse_event  out  1  one-cycle strobe marking an accepted photon.
REQ-013 event_light_timer  out  TS_WIDTH  phase stamp of the accepted photon; valid while pulse_event=1.
REQ-014 event_in_phase  out  1  I level at the photon edge.
REQ-015 event_quadrature  out  1  Q level at the photon edge.
REQ-016 accepted_count  out  32  saturating count of accepted events.
REQ-017 glitch_count  out  32  saturating count of pulses rejected for short width.
REQ-018 deadtime_count  out  32  saturating count of edges rejected during dead time.

Function
REQ-019 PMT_in SHALL pass through SYNC_STAGES flops; s = last stage, s_prev = s delayed one cycle; a rising edge (edge) is defined as s=1 and s_prev=0.
REQ-020 The FSM SHALL have states IDLE, QUALIFY and DEAD, with reset state IDLE.
REQ-021 IDLE: on edge at cycle E, the block SHALL latch light_timer, in_phase and quadrature from cycle E, load the width counter to 1, and go to QUALIFY.
REQ-022 QUALIFY: if s=0, the block SHALL increment glitch_count and go to IDLE; otherwise, once the width counter reaches MIN_WIDTH, it SHALL go to DEAD.
REQ-023 pulse_event SHALL be 1 for exactly one cycle, at cycle E+MIN_WIDTH, provided s=1 throughout E..E+MIN_WIDTH-1; accepted_count SHALL increment in that same cycle.
REQ-024 When MIN_WIDTH=1, the edge itself SHALL qualify the pulse, and pulse_event SHALL be asserted at cycle E+1.
REQ-025 event_light_timer, event_in_phase and event_quadrature SHALL hold the values latched at E until the next latch.
REQ-026 DEAD: the state SHALL last exactly DEAD_TIME cycles starting at the pulse_event cycle, and then return to IDLE.
REQ-027 In DEAD, every edge SHALL increment deadtime_count and SHALL NOT extend the dead time (non-paralyzable).
REQ-028 A level still high when DEAD exits SHALL NOT create an event; only a subsequent edge in IDLE SHALL create one.
REQ-029 All counters SHALL saturate at 0xFFFFFFFF; an increment at saturation SHALL leave the value unchanged.
REQ-030 clear_counts SHALL zero all three counters on the next cycle; if clear_counts coincides with an increment, clear SHALL win and the result SHALL be 0.
REQ-031 clear_counts SHALL NOT affect the FSM state or the latched event fields.
REQ-032 At most one counter SHALL increment per cycle.

Reset
REQ-033 On reset=1 the block SHALL set state=IDLE, pulse_event=0, event_light_timer=0, event_in_phase=0, event_quadrature=0, all counters=0, and width and dead counters=0.
REQ-034 On reset, the synchronizer flops and s_prev SHALL be set to 1, so that PMT_in held high through reset produces no event.
REQ-035 Reset asserted in QUALIFY or DEAD SHALL abort the operation immediately, with no event and no counter increment in that cycle.

Verification
REQ-036 PMT_in high for 5 cycles with light_timer=123, in_phase=1, quadrature=0 at E: pulse_event at E+2 with stamp 123/1/0, and accepted_count=1.
REQ-037 PMT_in high for 1 cycle with MIN_WIDTH=2: no pulse_event, glitch_count=1, and state back in IDLE.
REQ-038 Second edge 4 cycles after an event with DEAD_TIME=10: deadtime_count=1, and a third edge 12 cycles after the event is accepted.
REQ-039 PMT_in held high across reset deassertion and then low for 3 cycles and high again: exactly one event, after the post-reset edge.
REQ-040 accepted_count preloaded to 0xFFFFFFFF by forcing, then one more accepted pulse: count stays 0xFFFFFFFF; clear_counts coinciding with an increment gives 0.
REQ-041 Reset pulsed at E+1 of a qualifying pulse: no pulse_event, all counters 0, and state IDLE.
